multiplier_with_memory: RTL and testbench

//   Reads two unsigned operands from an internal 8x4 constant ROM and multiplies them.
//   The ROM addresses come from addr1/addr2, and d_out presents the 8-bit product.
//   An iterative shift-add FSM forms the product, one multiplier bit per clock.
//   It runs continuously, re-sampling the addresses at the start of every pass.

---
 rtl/multiplier_with_memory.sv | 135 +++++++++++++
 tb/tb_multiplier_with_memory.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/multiplier_with_memory.sv
// -----------------------------------------------------------------------------
// multiplier_with_memory
//   Looks up two unsigned operands in a fixed 8-entry ROM and multiplies them
//   with an iterative shift-add FSM (one multiplier bit per clock). The block
//   free-runs: every pass re-samples the addresses, forms the product and
//   registers it on d_out, where it is held until the next pass replaces it.
//
//   Pass: IDLE (1) -> LOAD (1) -> MULT (WIDTH) -> DONE (1) = 7 clocks default.
//
// Ports
//   clk    in   1         rising-edge clock
//   rst    in   1         asynchronous reset, active low
//   addr1  in   ADDR_W    ROM address of multiplicand A
//   addr2  in   ADDR_W    ROM address of multiplier B
//   d_out  out  2*WIDTH   product A*B of the last completed pass
// -----------------------------------------------------------------------------
module multiplier_with_memory #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [ADDR_W-1:0]    addr2,
  output logic [2*WIDTH-1:0]   d_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MULT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     a_q, a_d;
  logic [PW-1:0]     b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     d_out_q, d_out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0]  rom_a;
  logic [WIDTH-1:0]  rom_b;
  logic [PW-1:0]     b_shift;

  // Constant lookup table; pure combinational decode, so there is no storage
  // to initialise or reset.
  function automatic logic [WIDTH-1:0] rom_read(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] word;
    case (int'(addr))
      1:       word = WIDTH'(12);
      2:       word = WIDTH'(6);
      3:       word = WIDTH'(7);
      4:       word = WIDTH'(8);
      5:       word = WIDTH'(1);
      6:       word = WIDTH'(15);
      7:       word = WIDTH'(3);
      default: word = '0;
    endcase
    return word;
  endfunction

  assign rom_a = rom_read(addr1);
  assign rom_b = rom_read(addr2);

  // Current multiplier bit is bit 0 of b shifted down by the step count;
  // shifting avoids a narrow-index part-select into the wide register.
  assign b_shift = b_q >> cnt_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;

    unique case (state_q)
      IDLE: state_d = LOAD;

      LOAD: begin
        a_d     = {{WIDTH{1'b0}}, rom_a};
        b_d     = {{WIDTH{1'b0}}, rom_b};
        acc_d   = '0;
        cnt_d   = '0;
        state_d = MULT;
      end

      MULT: begin
        if (b_shift[0]) begin
          acc_d = acc_q + (a_q << cnt_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        d_out_d = acc_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      d_out_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_multiplier_with_memory.sv
// -----------------------------------------------------------------------------
// tb_multiplier_with_memory
//   Self-checking bench. The reference model knows only the ROM table, the
//   7-clock pass length counted from reset release (addresses captured on the
//   2nd edge of each pass, result published on the 7th) and plain
//   multiplication. d_out is compared after every clock edge, plus directed
//   checks against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_multiplier_with_memory;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic [2:0] addr1 = '0;
  logic [2:0] addr2 = '0;
  logic [7:0] d_out;

  always #5 clk = ~clk;

  multiplier_with_memory #(
    .WIDTH (4),
    .ADDR_W(3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .addr1(addr1),
    .addr2(addr2),
    .d_out(d_out)
  );

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;        // edges since reset release
  logic [7:0] exp_q = '0;     // model's expected d_out
  logic [7:0] pend  = '0;     // product of the pass in flight
  logic [3:0] rom_m [8] = '{4'd0, 4'd12, 4'd6, 4'd7, 4'd8, 4'd1, 4'd15, 4'd3};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // One clock: advance the model at the edge, compare #1 later.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      edge_n = 0;
      exp_q  = '0;
    end else begin
      edge_n++;
      if (edge_n % 7 == 2)
        pend = 8'(rom_m[addr1]) * 8'(rom_m[addr2]);
      else if (edge_n % 7 == 0)
        exp_q = pend;
    end
    #1 check("model", d_out, exp_q);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the model's pass phase equals ph; bounded.
  task automatic wait_phase(input int ph);
    int k = 0;
    while ((edge_n % 7 != ph) && (k < 20)) begin
      tick();
      k++;
    end
    vectors++;
    assert (edge_n % 7 == ph)
    else begin
      miscompares++;
      $error("FAIL wait_phase: observed phase %0d expected %0d", edge_n % 7, ph);
    end
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, hold 2 clocks, release.
  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    #1;
    edge_n = 0;
    exp_q  = '0;
    check(tag, d_out, 8'd0);
    ticks(2);
    #2 rst = 1'b1;
  endtask

  initial begin
    // 1. Reset held for 2 clocks, then first result on the 7th edge.
    rst   = 1'b0;
    addr1 = 3'd1;
    addr2 = 3'd2;
    ticks(2);
    check("reset_dout", d_out, 8'd0);
    #2 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("pre_first", d_out, 8'd0);
    end
    tick();
    check("first_result", d_out, 8'd72);

    // 2. Stable over later passes.
    ticks(20);
    check("hold_12x6", d_out, 8'd72);

    // 3. New operands visible within 14 clocks.
    addr1 = 3'd3;
    addr2 = 3'd4;
    ticks(14);
    check("7x8", d_out, 8'd56);

    // 4. Zero operand, then maximum product.
    addr1 = 3'd0;
    addr2 = 3'd5;
    ticks(14);
    check("0x1", d_out, 8'd0);
    addr1 = 3'd6;
    addr2 = 3'd6;
    ticks(14);
    check("15x15", d_out, 8'd225);

    // 5. Address change during MULT does not disturb the pass in flight.
    wait_phase(0);
    addr1 = 3'd1;
    addr2 = 3'd2;
    wait_phase(4);
    addr2 = 3'd3;
    wait_phase(0);
    check("mid_mult_old", d_out, 8'd72);
    ticks(7);
    check("mid_mult_new", d_out, 8'd84);

    // 6. Reset mid-MULT clears d_out immediately; normal pass afterwards.
    wait_phase(5);
    pulse_reset("async_clear");
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_wait", d_out, 8'd0);
    end
    tick();
    check("post_rst_result", d_out, 8'd84);

    // Randomised addresses changing at random moments, one random reset.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        addr1 = 3'($urandom_range(0, 7));
        addr2 = 3'($urandom_range(0, 7));
      end
      if (it == 200) pulse_reset("rand_reset");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
